alto_control_taskswitch: RTL and testbench
==========================================

ALTO_CONTROL_TASKSWITCH -- requirements
Module: alto_control_taskswitch

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port wakeup_i, input, 16: level wakeup request per task, bit n = task n; bit 0 ignored (emulator always awake).
REQ-004 SHALL have port task_switch_i, input, 1: current microinstruction executes TASK.
REQ-005 SHALL have port stall_i, input, 1: freeze all state this cycle.
REQ-006 SHALL have port initializing_i, input, 1: task-context MPC store is initializing.
REQ-007 SHALL have port rmr_load_i, input, 1: load RMR from bus_i.
REQ-008 SHALL have port bus_i, input, 16: data for RMR load.
REQ-009 SHALL have port clear_rmr_i, input, 1: set RMR to all ones.
REQ-010 SHALL have port task_o, output, 4: current task.
REQ-011 SHALL have port next_task_o, output, 4: task current in the next cycle.
REQ-012 SHALL have port rmr_o, output, 16: reset mode register.
REQ-013 SHALL have port switched_o, output, 1: one-cycle pulse, task_o changed at the last edge.

Function
REQ-014 SHALL register wakeup_i into wake_q each cycle stall_i is low, forcing wake_q[0]=1; the candidate SHALL come from wake_q only (one-cycle sampling latency).
REQ-015 Candidate SHALL be the highest set index of wake_q (15 highest priority, 0 lowest); always defined because bit 0 is set.
REQ-016 next_task_o SHALL be combinational: 0 while initializing_i; else the candidate when task_switch_i=1 and stall_i=0; else task_o.
REQ-017 task_o SHALL load next_task_o at each edge where stall_i=0; with stall_i=1 task_o, wake_q and switched_o SHALL hold.
REQ-018 switched_o SHALL be 1 for exactly the cycle after an edge at which task_o took a different value; TASK selecting the current task SHALL not pulse.
REQ-019 While initializing_i=1, task_o SHALL be forced to 0 at every edge regardless of stall_i; task_switch_i ignored.
REQ-020 rmr_o update priority: clear_rmr_i (to 16'hFFFF) over rmr_load_i (to bus_i); neither -> hold; RMR updates SHALL ignore stall_i.
REQ-021 Simultaneous rmr_load_i and task_switch_i SHALL both take effect in the same cycle.
REQ-022 Wakeup deasserting after sampling SHALL not cancel a switch already committed to task_o.

Reset
REQ-023 On an edge with rst_ni=0: task_o=0, wake_q=16'h0001, rmr_o=16'hFFFF, switched_o=0; next_task_o therefore 0.
REQ-024 Reset SHALL override stall_i, initializing_i, clear_rmr_i and rmr_load_i; reset mid-switch abandons the switch.

Structure
REQ-025 Task numbers (TASK_EMU=0, 16 tasks, 4-bit width) and RMR reset value 16'hFFFF SHALL live in the shared Alto control package.
REQ-026 The 16-to-4 priority encoder SHALL be one sub-module, alto_control_taskprio; all registers in the top module.

Verification
REQ-027 Reset, wakeup_i=0, repeated TASK -> task_o stays 0, switched_o never asserts, rmr_o=16'hFFFF.
REQ-028 wakeup_i=16'h0110 for 2 cycles, then TASK -> next_task_o=8 that cycle, task_o=8 and switched_o=1 next cycle.
REQ-029 Running task 8, wakeup_i[8] drops, TASK with wake_q=16'h0001 -> task_o=0 next cycle, switched_o=1.
REQ-030 TASK with stall_i=1 and wakeup_i=16'h8000 held -> task_o unchanged while stalled; after stall drops and TASK repeats -> task_o=15.
REQ-031 rmr_load_i with bus_i=16'h1234, then clear_rmr_i and rmr_load_i together -> rmr_o=16'h1234 then 16'hFFFF.
REQ-032 initializing_i=1 while task_o=5 and TASK with wakeup_i=16'hFFFF -> next_task_o=0, task_o=0 next edge, even with stall_i=1.

Source files
------------

// File: rtl/alto_control_taskswitch_pkg.sv
// Shared Alto control package.
// Holds the task numbering and the reset value of the reset mode register (RMR),
// so the task switcher and anything else decoding task numbers agree on them.
package alto_control_taskswitch_pkg;

  localparam int unsigned TASK_W    = 4;
  localparam int unsigned NUM_TASKS = 16;

  typedef logic [TASK_W-1:0]    task_t;
  typedef logic [NUM_TASKS-1:0] task_mask_t;

  // The emulator is task 0 and is always awake, so it is the fallback task.
  localparam task_t TASK_EMU = 4'd0;

  localparam logic [15:0] RMR_RESET = 16'hFFFF;

endpackage

// File: rtl/alto_control_taskprio.sv
// 16-to-4 priority encoder for task selection.
//   req : one request bit per task (bit 15 highest priority)
//   idx : number of the highest set request bit; TASK_EMU when none is set
module alto_control_taskprio
  import alto_control_taskswitch_pkg::*;
(
  input  task_mask_t req,
  output task_t      idx
);

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx = TASK_EMU;
    // Ascending scan: a later (higher) set bit overrides earlier ones.
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (req[i]) idx = task_t'(i);
    end
  end

endmodule

// File: rtl/alto_control_taskswitch.sv
// Alto microcode task switcher.
// Samples the per-task wakeup requests, picks the highest-priority awake task
// when the current microinstruction executes TASK, and maintains the reset mode
// register (RMR).
//   clk_i          : clock, all state on the rising edge
//   rst_ni         : synchronous active-low reset
//   wakeup_i       : level wakeup per task (bit 0 ignored, emulator always awake)
//   task_switch_i  : current microinstruction executes TASK
//   stall_i        : freeze task state this cycle (RMR still updates)
//   initializing_i : task-context store initializing; forces task 0
//   rmr_load_i     : load RMR from bus_i
//   bus_i          : RMR load data
//   clear_rmr_i    : set RMR to all ones (wins over rmr_load_i)
//   task_o         : current task
//   next_task_o    : task that will be current in the next cycle
//   rmr_o          : reset mode register
//   switched_o     : one-cycle pulse after task_o changed
module alto_control_taskswitch
  import alto_control_taskswitch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] wakeup_i,
  input  logic        task_switch_i,
  input  logic        stall_i,
  input  logic        initializing_i,
  input  logic        rmr_load_i,
  input  logic [15:0] bus_i,
  input  logic        clear_rmr_i,
  output logic [3:0]  task_o,
  output logic [3:0]  next_task_o,
  output logic [15:0] rmr_o,
  output logic        switched_o
);

  task_mask_t  wake_q;
  task_t       task_q;
  task_t       candidate;
  task_t       task_d;
  logic        switched_q;
  logic [15:0] rmr_q;

  // The candidate comes only from the registered wakeups, giving the
  // one-cycle sampling latency the microcode expects.
  alto_control_taskprio u_prio (
    .req (wake_q),
    .idx (candidate)
  );

  always_comb begin
    next_task_o = task_q;
    if (initializing_i)                  next_task_o = TASK_EMU;
    else if (task_switch_i && !stall_i)  next_task_o = candidate;
  end

  // Value task_q takes at the coming edge (outside reset). Initialization
  // forces task 0 even while stalled.
  always_comb begin
    task_d = task_q;
    if (initializing_i)  task_d = TASK_EMU;
    else if (!stall_i)   task_d = next_task_o;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wake_q     <= task_mask_t'(1);
      task_q     <= TASK_EMU;
      switched_q <= 1'b0;
    end else begin
      if (!stall_i) wake_q <= wakeup_i | task_mask_t'(1);
      // Pulse only on an actual change of task; re-selecting the running task
      // is silent. A forced return to task 0 during initialization still pulses.
      if (!stall_i || initializing_i) switched_q <= (task_d != task_q);
      task_q <= task_d;
    end
  end

  // RMR is independent of stall_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)          rmr_q <= RMR_RESET;
    else if (clear_rmr_i) rmr_q <= RMR_RESET;
    else if (rmr_load_i)  rmr_q <= bus_i;
  end

  assign task_o     = task_q;
  assign rmr_o      = rmr_q;
  assign switched_o = switched_q;

endmodule

// File: tb/tb_alto_control_taskswitch.sv
// Directed self-checking bench for alto_control_taskswitch.
module tb_alto_control_taskswitch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] wakeup_i;
  logic        task_switch_i;
  logic        stall_i;
  logic        initializing_i;
  logic        rmr_load_i;
  logic [15:0] bus_i;
  logic        clear_rmr_i;
  logic [3:0]  task_o;
  logic [3:0]  next_task_o;
  logic [15:0] rmr_o;
  logic        switched_o;

  int total = 0;
  int bad   = 0;

  alto_control_taskswitch dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wakeup_i       (wakeup_i),
    .task_switch_i  (task_switch_i),
    .stall_i        (stall_i),
    .initializing_i (initializing_i),
    .rmr_load_i     (rmr_load_i),
    .bus_i          (bus_i),
    .clear_rmr_i    (clear_rmr_i),
    .task_o         (task_o),
    .next_task_o    (next_task_o),
    .rmr_o          (rmr_o),
    .switched_o     (switched_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_task(input string tag, input logic [3:0] t, input logic sw);
    check({tag, ".task"},     16'(task_o),     16'(t));
    check({tag, ".switched"}, 16'(switched_o), 16'(sw));
  endtask

  initial begin
    rst_ni = 1'b0; wakeup_i = 16'h0; task_switch_i = 1'b0; stall_i = 1'b0;
    initializing_i = 1'b0; rmr_load_i = 1'b0; bus_i = 16'h0; clear_rmr_i = 1'b0;
    tick(); tick();
    chk_task("reset", 4'd0, 1'b0);
    check("reset.rmr",  rmr_o, 16'hFFFF);
    check("reset.next", 16'(next_task_o), 16'h0);

    // No wakeups, repeated TASK: emulator keeps running.
    rst_ni = 1'b1; task_switch_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_task("idle", 4'd0, 1'b0);
    end
    check("idle.rmr", rmr_o, 16'hFFFF);
    task_switch_i = 1'b0;

    // Wakeups 4 and 8 -> task 8 wins.
    wakeup_i = 16'h0110;
    tick(); tick();
    task_switch_i = 1'b1; #1;
    check("w8.next", 16'(next_task_o), 16'd8);
    tick();
    chk_task("w8", 4'd8, 1'b1);
    tick();  // TASK again selects the running task: no pulse
    chk_task("w8.same", 4'd8, 1'b0);
    task_switch_i = 1'b0;

    // Task 8 wakeup drops -> back to emulator.
    wakeup_i = 16'h0000;
    tick();
    task_switch_i = 1'b1; #1;
    check("drop.next", 16'(next_task_o), 16'd0);
    tick();
    chk_task("drop", 4'd0, 1'b1);

    // Stall freezes task, wake_q and switched_o.
    stall_i = 1'b1; wakeup_i = 16'h8000; #1;
    check("stall.next", 16'(next_task_o), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_task("stall", 4'd0, 1'b1);
    end
    stall_i = 1'b0; task_switch_i = 1'b0;
    tick();
    chk_task("unstall", 4'd0, 1'b0);
    task_switch_i = 1'b1;
    tick();
    chk_task("w15", 4'd15, 1'b1);
    task_switch_i = 1'b0;

    // RMR load together with a task switch.
    wakeup_i = 16'h0000;
    tick();
    task_switch_i = 1'b1; rmr_load_i = 1'b1; bus_i = 16'h1234;
    tick();
    check("rmr.load", rmr_o, 16'h1234);
    chk_task("rmr.sw", 4'd0, 1'b1);
    task_switch_i = 1'b0; clear_rmr_i = 1'b1; bus_i = 16'h5555; stall_i = 1'b1;
    tick();
    check("rmr.clear", rmr_o, 16'hFFFF);
    clear_rmr_i = 1'b0; bus_i = 16'h00AA;
    tick();
    check("rmr.stall_load", rmr_o, 16'h00AA);
    rmr_load_i = 1'b0; stall_i = 1'b0;
    tick();
    check("rmr.hold", rmr_o, 16'h00AA);

    // Initialization forces task 0 even while stalled.
    wakeup_i = 16'h0020;
    tick();
    task_switch_i = 1'b1;
    tick();
    chk_task("w5", 4'd5, 1'b1);
    initializing_i = 1'b1; wakeup_i = 16'hFFFF; stall_i = 1'b1; #1;
    check("init.next", 16'(next_task_o), 16'd0);
    tick();
    check("init.task", 16'(task_o), 16'd0);
    initializing_i = 1'b0; stall_i = 1'b0; task_switch_i = 1'b0;
    tick();

    // Wakeup dropping after sampling does not cancel the switch.
    wakeup_i = 16'h0400;
    tick();
    task_switch_i = 1'b1; wakeup_i = 16'h0000;
    tick();
    chk_task("late", 4'd10, 1'b1);
    task_switch_i = 1'b0;
    tick();
    chk_task("late.hold", 4'd10, 1'b0);

    // Reset mid-switch abandons it and overrides the RMR load.
    wakeup_i = 16'h0800;
    tick();
    task_switch_i = 1'b1; rst_ni = 1'b0; rmr_load_i = 1'b1; bus_i = 16'h1111;
    tick();
    chk_task("rst_mid", 4'd0, 1'b0);
    check("rst_mid.rmr", rmr_o, 16'hFFFF);
    rst_ni = 1'b1; rmr_load_i = 1'b0; task_switch_i = 1'b0; wakeup_i = 16'h0000;
    tick();
    task_switch_i = 1'b1; #1;
    check("rst_mid.next", 16'(next_task_o), 16'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
